// File: rtl/rv_lsu_bus.sv
// rv_lsu_bus: load/store bridge from the pipeline control path to a word-wide data bus.
// Build macro RV_LSU_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into access faults.
module rv_lsu_bus #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_t      state_r, state_nxt_s;
  logic        req_s, we_s, bad_s, to_s;
  logic [1:0]  ofs_s, ofs_r;
  logic [2:0]  f3_r;
  logic [7:0]  cnt_r;

  function automatic logic f3_bad(input logic [2:0] f3, input logic we);
    case (f3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = we;
      default:                f3_bad = 1'b1;
    endcase
  endfunction

  // Byte lane of the access inside the word; H and W are aligned down.
  function automatic logic [1:0] lane_ofs(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_ofs = a;
      2'b01:   lane_ofs = {a[1], 1'b0};
      default: lane_ofs = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   byte_en = 4'b0001 << ofs;
      2'b01:   byte_en = 4'b0011 << ofs;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {ofs, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'd0, sh[7:0]};
      3'b101:  load_ext = {16'd0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

`ifdef RV_LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    misaligned = ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
  endfunction

  assign bad_s = f3_bad(funct3_i, we_s) || misaligned(funct3_i[1:0], addr_i[1:0]);
`else
  assign bad_s = f3_bad(funct3_i, we_s);
`endif

  // A simultaneous read and write request is handled as a store.
  assign req_s = mem_read_i | mem_write_i;
  assign we_s  = mem_write_i;
  assign ofs_s = lane_ofs(funct3_i[1:0], addr_i[1:0]);
  assign to_s  = (cnt_r == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE always retires to IDLE so a held request is not replayed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          state_nxt_s = bad_s ? S_DONE : S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus_ack_i || to_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Pipeline hold, combinational so the requesting instruction freezes in its first cycle.
  always_comb begin
    stall_o = 1'b0;
    case (state_r)
      S_IDLE:  stall_o = req_s;
      S_WAIT:  stall_o = 1'b1;
      S_DONE:  stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  // Registered bus signals, timeout counter, completion pulses and load result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= 32'd0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= 32'd0;
      cnt_r       <= 8'd0;
      f3_r        <= 3'b000;
      ofs_r       <= 2'b00;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            cnt_r <= 8'd0;
            f3_r  <= funct3_i;
            ofs_r <= ofs_s;
            if (bad_s) begin
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= 32'd0;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= we_s;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= byte_en(funct3_i[1:0], ofs_s);
              bus_wdata_o <= store_data(funct3_i[1:0], wdata_i);
            end
          end
        end
        S_WAIT: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            rdata_o   <= bus_we_o ? 32'd0 : load_ext(f3_r, ofs_r, bus_rdata_i);
          end else if (to_s) begin
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            rdata_o   <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv_lsu_bus.sv
// tb_rv_lsu_bus: table-driven directed bench for rv_lsu_bus (TO_CYC = 4) plus hand-written
// sequences for stray acks and reset during a bus wait.
module tb_rv_lsu_bus;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  rv_lsu_bus #(.TO_CYC(4)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, brd;
    int          ack_at;      // WAIT cycle carrying the ack, 0 = never
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    logic        e_err;
    int          e_waits;     // cycles with bus_req_o high
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] brd, int ack_at,
                              logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wd,
                              logic [31:0] e_rd, logic e_err, int e_waits);
    vec_t v;
    v = '{rd, wr, f3, addr, wdata, brd, ack_at, e_addr, e_be, e_wd, e_rd, e_err, e_waits};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int waits;
    int stalls;
    bit got;
    waits = 0;
    stalls = 0;
    got = 1'b0;
    @(negedge clk);
    mem_read_i  = v.rd;
    mem_write_i = v.wr;
    funct3_i    = v.f3;
    addr_i      = v.addr;
    wdata_i     = v.wdata;
    bus_ack_i   = 1'b0;
    bus_rdata_i = v.brd;
    #1;
    if (stall_o) stalls++;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
      end else begin
        if (stall_o) stalls++;
        if (bus_req_o) begin
          waits++;
          chk($sformatf("v%0d bus_addr", idx), bus_addr_o, v.e_addr);
          chk($sformatf("v%0d bus_be", idx), {28'd0, bus_be_o}, {28'd0, v.e_be});
          chk($sformatf("v%0d bus_we", idx), {31'd0, bus_we_o}, {31'd0, v.wr});
          if (v.wr) chk($sformatf("v%0d bus_wdata", idx), bus_wdata_o, v.e_wd);
        end
        bus_ack_i = (v.ack_at != 0) && (waits == v.ack_at);
      end
    end
    bus_ack_i = 1'b0;
    chk($sformatf("v%0d done seen", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d err", idx), {31'd0, err_o}, {31'd0, v.e_err});
    chk($sformatf("v%0d rdata", idx), rdata_o, v.e_rd);
    chk($sformatf("v%0d req cycles", idx), waits, v.e_waits);
    chk($sformatf("v%0d stall cycles", idx), stalls, v.e_waits + 1);
    chk($sformatf("v%0d stall in done", idx), {31'd0, stall_o}, 32'd0);
    // Request is still held across the DONE-ending edge and must not restart an access.
    @(negedge clk);
    chk($sformatf("v%0d done single", idx), {31'd0, done_o}, 32'd0);
    chk($sformatf("v%0d no replay", idx), {31'd0, bus_req_o}, 32'd0);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t last;
    rstn = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'd0; wdata_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;

    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 3,
                     32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0,
                     32'h300, 4'b1111, 32'h0, 32'h0, 1'b1, 4));
    tbl.push_back(mk(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hDEADBEEF, 1,
                     32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1));
`ifdef RV_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1'b1, 1'b0, 3'b101, 32'h101, 32'h0, 32'h1111F00D, 2,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0));
`else
    tbl.push_back(mk(1'b1, 1'b0, 3'b101, 32'h101, 32'h0, 32'h1111F00D, 2,
                     32'h100, 4'b0011, 32'h0, 32'h0000F00D, 1'b0, 2));
`endif
    tbl.push_back(mk(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 32'h87654321, 1,
                     32'h104, 4'b1100, 32'h0, 32'hFFFF8765, 1'b0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 32'h1234F678, 2,
                     32'h000, 4'b0010, 32'h0, 32'h000000F6, 1'b0, 2));
    tbl.push_back(mk(1'b0, 1'b1, 3'b000, 32'h00B, 32'h0000005A, 32'h0, 1,
                     32'h008, 4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0, 2,
                     32'h010, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 32'h004, 32'h0, 32'h000000FE, 1,
                     32'h004, 4'b0001, 32'h0, 32'hFFFFFFFE, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b100, 32'h020, 32'h11, 32'h0, 1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 32'h024, 32'h01020304, 32'hFFFFFFFF, 1,
                     32'h024, 4'b1111, 32'h01020304, 32'h0, 1'b0, 1));
`ifdef RV_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h016, 32'h0, 32'h89ABCDEF, 1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0));
`else
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h016, 32'h0, 32'h89ABCDEF, 1,
                     32'h014, 4'b1111, 32'h0, 32'h89ABCDEF, 1'b0, 1));
`endif
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 32'h7FFE0000, 1,
                     32'h000, 4'b1100, 32'h0, 32'h00007FFE, 1'b0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b101, 32'h10A, 32'h0, 32'hBEEF1234, 3,
                     32'h108, 4'b1100, 32'h0, 32'h0000BEEF, 1'b0, 3));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("reset bus_we", {31'd0, bus_we_o}, 32'd0);
    chk("reset bus_be", {28'd0, bus_be_o}, 32'd0);
    chk("reset done", {31'd0, done_o}, 32'd0);
    chk("reset err", {31'd0, err_o}, 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    rstn = 1'b1;

    foreach (tbl[i]) run_vec(i, tbl[i]);
    last = tbl[tbl.size() - 1];

    // Stray ack while idle must leave every output untouched.
    @(negedge clk);
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray ack rdata", rdata_o, last.e_rd);
      chk("stray ack done", {31'd0, done_o}, 32'd0);
      chk("stray ack bus_req", {31'd0, bus_req_o}, 32'd0);
      chk("stray ack err", {31'd0, err_o}, 32'd0);
    end
    bus_ack_i = 1'b0;

    // Reset arriving together with the ack abandons the access.
    @(negedge clk);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
    bus_rdata_i = 32'h55555555;
    @(negedge clk);
    chk("rst-wait bus_req before", {31'd0, bus_req_o}, 32'd1);
    rstn = 1'b0;
    bus_ack_i = 1'b1;
    @(negedge clk);
    mem_read_i = 1'b0;
    bus_ack_i = 1'b0;
    #1;
    chk("rst-wait bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst-wait done", {31'd0, done_o}, 32'd0);
    chk("rst-wait err", {31'd0, err_o}, 32'd0);
    chk("rst-wait rdata", rdata_o, 32'd0);
    chk("rst-wait stall", {31'd0, stall_o}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst-wait done after", {31'd0, done_o}, 32'd0);
    chk("rst-wait bus_req after", {31'd0, bus_req_o}, 32'd0);

    // Normal operation resumes after the abandoned access.
    run_vec(100, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_lsu_bus.md
RV_LSU_BUS -- requirements
Module: rv_lsu_bus

Interface
REQ-001 SHALL have parameter TO_CYC, default 255, meaning bus-ack timeout in cycles (1..255).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port mem_read_i  in  1  load request from control path.
REQ-005 SHALL have port mem_write_i  in  1  store request from control path.
REQ-006 SHALL have port funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port addr_i  in  32  byte address from ALU.
REQ-008 SHALL have port wdata_i  in  32  store data (rs2).
REQ-009 SHALL have port stall_o  out  1  hold pipeline.
REQ-010 SHALL have port rdata_o  out  32  extended load result.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  out  1  one-cycle access-fault pulse, coincident with done_o.
REQ-013 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_be_o out 4, bus_wdata_o out 32, bus_ack_i in 1, bus_rdata_i in 32 (word data-memory bus).

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-015 IDLE: mem_read_i or mem_write_i high at clk edge SHALL latch addr/funct3/wdata/direction and enter WAIT; both high SHALL be treated as store.
REQ-016 Invalid funct3 (011, 110, 111, or 100/101 with store) SHALL skip WAIT, enter DONE with err_o=1, no bus access.
REQ-017 WAIT: bus_req_o=1 with bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o stable until bus_ack_i sampled high.
REQ-018 bus_addr_o SHALL be {addr[31:2],2'b00}.
REQ-019 bus_be_o SHALL be 0001<<addr[1:0] (B), 0011<<{addr[1],0} (H), 1111 (W).
REQ-020 bus_wdata_o SHALL be {4{wdata[7:0]}} (SB), {2{wdata[15:0]}} (SH), wdata (SW).
REQ-021 Ack in WAIT SHALL capture bus_rdata_i and enter DONE next edge; minimum latency request-to-done_o is 2 cycles.
REQ-022 8-bit timeout counter SHALL reset on WAIT entry; reaching TO_CYC without ack SHALL drop bus_req_o and enter DONE with err_o=1.
REQ-023 rdata_o SHALL be (bus_rdata>>8*addr[1:0]) sign-extended (B,H) or zero-extended (BU,HU), full word for W; 0 for stores and errors; held until next load completes.
REQ-024 stall_o SHALL be combinational: 1 when (IDLE and request present) or WAIT; 0 in DONE.
REQ-025 Requests present during DONE SHALL be ignored (same instruction retiring).
REQ-026 Ack outside WAIT SHALL be ignored.

Reset
REQ-027 rstn low at edge SHALL force IDLE, counter 0, rdata_o 0, bus_req_o/bus_we_o/done_o/err_o 0, bus_be_o 0.
REQ-028 Reset during WAIT SHALL drop bus_req_o at that edge, abandoning the access without done_o.

Configuration
REQ-029 With RV_LSU_MISALIGN_TRAP_EN defined, H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL go IDLE->DONE with err_o=1, no bus access.
REQ-030 Without RV_LSU_MISALIGN_TRAP_EN, misaligned addresses SHALL be aligned down (H: addr[0] ignored; W: addr[1:0] ignored) and accessed normally.

Verification
REQ-031 LB addr 0x103, ack after 3 cycles with rdata 0x80AABBCC -> bus_be_o 1000, rdata_o 0xFFFFFF80, done_o once, stall_o high 4 cycles.
REQ-032 SH addr 0x202, wdata 0x1234ABCD, immediate ack -> bus_addr_o 0x200, bus_be_o 1100, bus_wdata_o 0xABCDABCD, done_o 2 cycles after request.
REQ-033 LW, ack never asserted, TO_CYC=4 -> bus_req_o high 4 cycles then low, done_o=err_o=1, rdata_o 0.
REQ-034 LHU addr 0x101: macro defined -> err_o=1, no bus_req_o; undefined -> be 0011, rdata_o zero-extended low half.
REQ-035 rstn low during WAIT with ack arriving same cycle -> IDLE, no done_o, bus_req_o 0 next cycle.
REQ-036 funct3=011 load -> err_o=1, bus_req_o never asserted; stray bus_ack_i in IDLE -> no output change.
